eeprom_seq_arb: RTL and testbench
=================================

Name: eeprom_seq_arb

Overview:
- Sequences and shares the EEPROM OPB register port (EEP_DI/EEP_WE/EEP_DO) between two byte-level requesters.
- Arbitrates round-robin and turns each byte request into the full SPI EEPROM command sequence.
  - Write request: WREN, then WRITE, then RDSR polling until WIP clears.
  - Read request: single READ.
- Sits between firmware/boot-load requesters and the EEPROM OPB interface; one transaction in flight at a time.

Parameters:
- TIMEOUT_CYC, 20000: max OPB_CLK cycles waiting for EEP_DO[31] per command; 16-bit counter.
- MAX_POLL, 1000: max RDSR polls per write before error; 12-bit counter.
- INST_READ, 4'h3: instruction code for READ.
- INST_WRITE, 4'h2: instruction code for WRITE.
- INST_WREN, 4'h6: instruction code for WREN.
- INST_RDSR, 4'h5: instruction code for RDSR.

Ports:
- OPB_CLK  in  1  clock
- OPB_RST  in  1  reset, asynchronous, active-high
- req0_req  in  1  requester 0 request, level, held until ack
- req0_wr  in  1  1=write, 0=read; stable while req high
- req0_addr  in  16  byte address
- req0_wdata  in  8  write data
- req0_ack  out  1  one-cycle completion pulse
- req0_rdata  out  8  read data, valid with ack
- req0_err  out  1  error flag, valid with ack
- req1_*  same set as req0 for requester 1
- eep_di  out  32  command word {inst[3:0], 4'h0, addr[15:0], data[7:0]}
- eep_we  out  1  one-cycle command strobe
- eep_do  in  32  [31]=done (cleared by eep_we), [7:0]=read/status byte
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; rr pointer=1, so req0 wins first contention.
- Handshake:
  - Requester holds req and all fields stable until ack.
  - ack is exactly one cycle; rdata/err valid in that cycle and held until the next ack to the same requester.
  - Requester deasserts req in the cycle after ack.
- Arbitration (IDLE): if exactly one req is high, grant it. If both are high, grant the one not equal to rr. Latch wr/addr/wdata, set rr=grant, go to ISSUE.
- Command issue:
  - Each command drives eep_di and pulses eep_we for one cycle, then enters a WAIT state.
  - WAIT ignores eep_do[31] in its first cycle (done_reg clears on the WE edge).
  - WAIT then waits for eep_do[31]=1.
  - The wait counter resets on each eep_we. Reaching TIMEOUT_CYC aborts with err.
- FSM states: IDLE, WREN_ISS, WREN_WAIT, OP_ISS, OP_WAIT, POLL_ISS, POLL_WAIT, RESP.
  - Read: IDLE -> OP_ISS(INST_READ) -> OP_WAIT; capture eep_do[7:0] into rdata -> RESP.
  - Write:
    - IDLE -> WREN_ISS(addr=0, data=0) -> WREN_WAIT -> OP_ISS(INST_WRITE, addr, wdata) -> OP_WAIT -> POLL_ISS(INST_RDSR).
    - POLL_WAIT: if eep_do[0] (WIP)=1, go back to POLL_ISS and increment poll_cnt; if WIP=0, go to RESP.
    - poll_cnt reaching MAX_POLL sets err and goes to RESP.
  - RESP: pulse granted reqN_ack with rdata/err -> IDLE.
- Error: on timeout or poll overflow, rdata=8'h00, err=1, and no further commands are issued for that request.
- Write ack: rdata=0.
- Reset mid-operation: FSM returns to IDLE immediately, eep_we=0, no ack issued; requesters must re-request.
- A request whose req drops before ack still completes internally; its ack is still pulsed.

Optional Feature:
- Macro EEPROM_SEQ_VERIFY_EN.
- Defined: after WIP clears on a write, add states VFY_ISS/VFY_WAIT, issuing INST_READ at the same addr.
  - On mismatch with wdata: err=1.
  - On match: err=0.
  - In both cases rdata=read-back byte.
- Undefined: write completes at WIP=0 with no read-back; VFY states are absent.

Test Plan:
- Read: req0 read addr 16'h0123; model returns 8'hA5 -> one eep_we with eep_di=32'h30012300; req0_ack with rdata=8'hA5, err=0.
- Write: req1 write addr 16'h0040, data 8'h5A; model WIP=1 for 3 polls -> eep_di sequence 32'h60000000, 32'h2000405A, then 4x 32'h50000000; req1_ack err=0.
- Contention: req0 and req1 raised same cycle after reset -> req0 served first, req1 next. Repeat with both raised again -> req1 served first.
- Timeout: model never sets done on a read -> ack after about TIMEOUT_CYC+2 cycles with err=1, rdata=0; busy drops the cycle after ack.
- Poll overflow: WIP stuck 1, MAX_POLL=4 -> exactly 4 RDSR commands, then ack err=1.
- Reset: OPB_RST asserted in POLL_WAIT -> all outputs 0 next sample; no ack. A subsequent read completes normally.

Source files
------------

// File: rtl/eeprom_seq_arb.sv
// eeprom_seq_arb: shares the EEPROM OPB register port between two byte-level
// requesters. Grants are round-robin. Each grant is expanded into the SPI EEPROM
// command sequence. A read is a single READ. A write is WREN, WRITE, then RDSR
// polling until WIP clears.
// Optional build macro EEPROM_SEQ_VERIFY_EN: after WIP clears, a write reads
// the byte back and flags err when it differs from the written data.
module eeprom_seq_arb #(
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned MAX_POLL    = 1000,
  parameter logic [3:0]  INST_READ   = 4'h3,
  parameter logic [3:0]  INST_WRITE  = 4'h2,
  parameter logic [3:0]  INST_WREN   = 4'h6,
  parameter logic [3:0]  INST_RDSR   = 4'h5
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        req0_req,
  input  logic        req0_wr,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ack,
  output logic [7:0]  req0_rdata,
  output logic        req0_err,
  input  logic        req1_req,
  input  logic        req1_wr,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ack,
  output logic [7:0]  req1_rdata,
  output logic        req1_err,
  output logic [31:0] eep_di,
  output logic        eep_we,
  input  logic [31:0] eep_do,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, WREN_ISS, WREN_WAIT, OP_ISS, OP_WAIT, POLL_ISS, POLL_WAIT, RESP
`ifdef EEPROM_SEQ_VERIFY_EN
    , VFY_ISS, VFY_WAIT
`endif
  } state_t;

  state_t      state, next_state;
  logic        grant_q, rr_q, wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata_q;
  logic        err_q;
  logic [15:0] wait_cnt;
  logic        wait_first;
  logic [11:0] poll_cnt;
  logic [7:0]  req0_rdata_q, req1_rdata_q;
  logic        req0_err_q, req1_err_q;

  // Only the done bit and the data byte of eep_do carry meaning here.
  logic unused_eep_do;
  assign unused_eep_do = ^eep_do[30:8];

  // Arbitration: a lone request wins; on contention the side not served last wins.
  logic any_req, arb_grant;
  assign any_req   = req0_req | req1_req;
  assign arb_grant = (req0_req & req1_req) ? ~rr_q : req1_req;

  logic in_wait, done_ok, timed_out, wip, poll_last;
  assign in_wait = (state == WREN_WAIT) || (state == OP_WAIT) || (state == POLL_WAIT)
`ifdef EEPROM_SEQ_VERIFY_EN
                   || (state == VFY_WAIT)
`endif
                   ;
  // The done flag is stale during the first WAIT cycle, so it is masked there.
  assign done_ok   = in_wait & ~wait_first & eep_do[31];
  assign timed_out = in_wait & ~done_ok & (wait_cnt == 16'(TIMEOUT_CYC - 1));
  assign wip       = eep_do[0];
  assign poll_last = (poll_cnt + 12'd1) == 12'(MAX_POLL);

  // State register.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (OPB_RST) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:      if (any_req) next_state = (arb_grant ? req1_wr : req0_wr) ? WREN_ISS : OP_ISS;
      WREN_ISS:  next_state = WREN_WAIT;
      WREN_WAIT: if (timed_out) next_state = RESP;
                 else if (done_ok) next_state = OP_ISS;
      OP_ISS:    next_state = OP_WAIT;
      OP_WAIT:   if (timed_out) next_state = RESP;
                 else if (done_ok) next_state = wr_q ? POLL_ISS : RESP;
      POLL_ISS:  next_state = POLL_WAIT;
      POLL_WAIT: if (timed_out) next_state = RESP;
                 else if (done_ok) begin
                   if (wip) next_state = poll_last ? RESP : POLL_ISS;
`ifdef EEPROM_SEQ_VERIFY_EN
                   else     next_state = VFY_ISS;
`else
                   else     next_state = RESP;
`endif
                 end
`ifdef EEPROM_SEQ_VERIFY_EN
      VFY_ISS:   next_state = VFY_WAIT;
      VFY_WAIT:  if (timed_out || done_ok) next_state = RESP;
`endif
      RESP:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output logic: command strobe/word, busy, and ack with its response.
  always_comb begin
    eep_we     = 1'b0;
    eep_di     = 32'h0;
    busy       = (state != IDLE);
    req0_ack   = 1'b0;
    req1_ack   = 1'b0;
    req0_rdata = req0_rdata_q;
    req0_err   = req0_err_q;
    req1_rdata = req1_rdata_q;
    req1_err   = req1_err_q;
    unique case (state)
      WREN_ISS: begin
        eep_we = 1'b1;
        eep_di = {INST_WREN, 28'h0};
      end
      OP_ISS: begin
        eep_we = 1'b1;
        eep_di = {wr_q ? INST_WRITE : INST_READ, 4'h0, addr_q, wr_q ? wdata_q : 8'h00};
      end
      POLL_ISS: begin
        eep_we = 1'b1;
        eep_di = {INST_RDSR, 28'h0};
      end
`ifdef EEPROM_SEQ_VERIFY_EN
      VFY_ISS: begin
        eep_we = 1'b1;
        eep_di = {INST_READ, 4'h0, addr_q, 8'h00};
      end
`endif
      RESP: begin
        if (grant_q) begin
          req1_ack   = 1'b1;
          req1_rdata = rdata_q;
          req1_err   = err_q;
        end else begin
          req0_ack   = 1'b1;
          req0_rdata = rdata_q;
          req0_err   = err_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath: grant latch, wait/poll counters, response capture and hold.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      grant_q      <= 1'b0;
      rr_q         <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0;
      wdata_q      <= 8'h0;
      rdata_q      <= 8'h0;
      err_q        <= 1'b0;
      wait_cnt     <= 16'h0;
      wait_first   <= 1'b0;
      poll_cnt     <= 12'h0;
      req0_rdata_q <= 8'h0;
      req1_rdata_q <= 8'h0;
      req0_err_q   <= 1'b0;
      req1_err_q   <= 1'b0;
    end else begin
      wait_first <= eep_we;
      if (eep_we)       wait_cnt <= 16'h0;
      else if (in_wait) wait_cnt <= wait_cnt + 16'd1;

      if (state == IDLE && any_req) begin
        grant_q  <= arb_grant;
        rr_q     <= arb_grant;
        wr_q     <= arb_grant ? req1_wr    : req0_wr;
        addr_q   <= arb_grant ? req1_addr  : req0_addr;
        wdata_q  <= arb_grant ? req1_wdata : req0_wdata;
        poll_cnt <= 12'h0;
        rdata_q  <= 8'h0;
        err_q    <= 1'b0;
      end

      if (timed_out) begin
        rdata_q <= 8'h0;
        err_q   <= 1'b1;
      end else if (done_ok) begin
        if (state == OP_WAIT && !wr_q) rdata_q <= eep_do[7:0];
        if (state == POLL_WAIT && wip) begin
          if (poll_last) err_q <= 1'b1;
          else           poll_cnt <= poll_cnt + 12'd1;
        end
`ifdef EEPROM_SEQ_VERIFY_EN
        if (state == VFY_WAIT) begin
          rdata_q <= eep_do[7:0];
          err_q   <= (eep_do[7:0] != wdata_q);
        end
`endif
      end

      if (state == RESP) begin
        if (grant_q) begin
          req1_rdata_q <= rdata_q;
          req1_err_q   <= err_q;
        end else begin
          req0_rdata_q <= rdata_q;
          req0_err_q   <= err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_eeprom_seq_arb.sv
// Directed bench for eeprom_seq_arb with a small EEPROM register-port model.
module tb_eeprom_seq_arb;

  localparam int T_CYC = 40;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic        req0_req = 1'b0, req0_wr = 1'b0;
  logic [15:0] req0_addr = 16'h0;
  logic [7:0]  req0_wdata = 8'h0;
  logic        req1_req = 1'b0, req1_wr = 1'b0;
  logic [15:0] req1_addr = 16'h0;
  logic [7:0]  req1_wdata = 8'h0;
  logic        req0_ack, req0_err, req1_ack, req1_err, eep_we, busy;
  logic [7:0]  req0_rdata, req1_rdata;
  logic [31:0] eep_di;
  logic [31:0] eep_do;

  int vectors = 0;
  int miscompares = 0;

  always #5 OPB_CLK = ~OPB_CLK;

  eeprom_seq_arb #(.TIMEOUT_CYC(T_CYC), .MAX_POLL(4)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST),
    .req0_req(req0_req), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_req(req1_req), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .eep_di(eep_di), .eep_we(eep_we), .eep_do(eep_do), .busy(busy)
  );

  // EEPROM port model: logs every command, raises done a few cycles later.
  logic [31:0] log_mem [0:63];
  int          log_n = 0;
  logic        pending;
  int          lat;
  logic [3:0]  cur_inst;
  int          rdsr_cnt;
  logic        hang = 1'b0;
  logic        wip_stuck = 1'b0;
  int          wip_polls = 0;
  logic [7:0]  mem_byte = 8'h0;

  always @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      eep_do   <= 32'h0;
      pending  <= 1'b0;
      lat      <= 0;
      cur_inst <= 4'h0;
      rdsr_cnt <= 0;
    end else if (eep_we) begin
      if (log_n < 64) log_mem[log_n] <= eep_di;
      log_n      <= log_n + 1;
      eep_do[31] <= 1'b0;
      pending    <= 1'b1;
      lat        <= 2;
      cur_inst   <= eep_di[31:28];
      if (eep_di[31:28] == 4'h2) rdsr_cnt <= 0;
    end else if (pending && !hang) begin
      if (lat == 0) begin
        pending    <= 1'b0;
        eep_do[31] <= 1'b1;
        case (cur_inst)
          4'h3: eep_do[7:0] <= mem_byte;
          4'h5: begin
            eep_do[7:0] <= {7'b0, (wip_stuck || (rdsr_cnt < wip_polls))};
            rdsr_cnt    <= rdsr_cnt + 1;
          end
          default: eep_do[7:0] <= 8'h00;
        endcase
      end else begin
        lat <= lat - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for an ack on either side; who=-1 if none arrived.
  task automatic wait_ack(input int budget, output int who, output int n);
    who = -1;
    n   = 0;
    while (n < budget) begin
      @(negedge OPB_CLK);
      n++;
      if (req0_ack) begin who = 0; return; end
      if (req1_ack) begin who = 1; return; end
    end
    check("ack_timeout", 32'(n), 32'(budget + 1));
  endtask

  initial begin
    int n, who, base, rdsr, seen;
    logic [31:0] exp_w [0:5];
    exp_w = '{32'h60000000, 32'h2000405A, 32'h50000000,
              32'h50000000, 32'h50000000, 32'h50000000};

    // Reset state
    repeat (3) @(negedge OPB_CLK);
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_we",     32'(eep_we), 32'h0);
    check("rst_di",     eep_di, 32'h0);
    check("rst_acks",   32'({req0_ack, req1_ack}), 32'h0);
    check("rst_rsp",    32'({req0_rdata, req0_err, req1_rdata, req1_err}), 32'h0);
    OPB_RST = 1'b0;
    @(negedge OPB_CLK);

    // Contention straight after reset: req0 first
    mem_byte = 8'h11;
    req0_wr = 1'b0; req0_addr = 16'h0010; req0_req = 1'b1;
    req1_wr = 1'b0; req1_addr = 16'h0020; req1_req = 1'b1;
    wait_ack(200, who, n);
    check("cont1_first", 32'(who), 32'd0);
    check("cont1_rdata", 32'(req0_rdata), 32'h11);
    req0_req = 1'b0;
    wait_ack(200, who, n);
    check("cont1_second", 32'(who), 32'd1);
    req1_req = 1'b0;
    @(negedge OPB_CLK);

    // Single read by req0
    base = log_n;
    mem_byte = 8'hA5;
    req0_wr = 1'b0; req0_addr = 16'h0123; req0_req = 1'b1;
    wait_ack(200, who, n);
    check("rd_who",   32'(who), 32'd0);
    check("rd_rdata", 32'(req0_rdata), 32'hA5);
    check("rd_err",   32'(req0_err), 32'h0);
    req0_req = 1'b0;
    @(negedge OPB_CLK);
    check("rd_ncmd", 32'(log_n - base), 32'd1);
    check("rd_di",   log_mem[base], 32'h30012300);
    check("rd_busy_after", 32'(busy), 32'h0);

    // Contention with req0 served last: req1 first
    mem_byte = 8'h22;
    req0_addr = 16'h0011; req0_req = 1'b1;
    req1_addr = 16'h0021; req1_req = 1'b1;
    wait_ack(200, who, n);
    check("cont2_first", 32'(who), 32'd1);
    check("cont2_rdata", 32'(req1_rdata), 32'h22);
    req1_req = 1'b0;
    wait_ack(200, who, n);
    check("cont2_second", 32'(who), 32'd0);
    req0_req = 1'b0;
    @(negedge OPB_CLK);

    // Write by req1 with WIP set for 3 polls
    base = log_n;
    wip_polls = 3;
    req1_wr = 1'b1; req1_addr = 16'h0040; req1_wdata = 8'h5A; req1_req = 1'b1;
    wait_ack(400, who, n);
    check("wr_who",   32'(who), 32'd1);
    check("wr_err",   32'(req1_err), 32'h0);
    check("wr_rdata", 32'(req1_rdata), 32'h0);
    req1_req = 1'b0;
    @(negedge OPB_CLK);
    check("wr_ncmd", 32'(log_n - base), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("wr_di%0d", i), log_mem[base + i], exp_w[i]);
    wip_polls = 0;

    // Timeout on a read: done never arrives
    base = log_n;
    hang = 1'b1;
    req0_wr = 1'b0; req0_addr = 16'h0300; req0_req = 1'b1;
    wait_ack(200, who, n);
    check("to_who",    32'(who), 32'd0);
    check("to_cycles", 32'(n), 32'(T_CYC + 2));
    check("to_err",    32'(req0_err), 32'h1);
    check("to_rdata",  32'(req0_rdata), 32'h0);
    req0_req = 1'b0;
    @(negedge OPB_CLK);
    check("to_busy_after", 32'(busy), 32'h0);
    check("to_ncmd", 32'(log_n - base), 32'd1);
    hang = 1'b0;

    // Poll overflow: WIP stuck with MAX_POLL=4
    base = log_n;
    wip_stuck = 1'b1;
    req1_wr = 1'b1; req1_addr = 16'h0050; req1_wdata = 8'h77; req1_req = 1'b1;
    wait_ack(600, who, n);
    check("po_who",   32'(who), 32'd1);
    check("po_err",   32'(req1_err), 32'h1);
    check("po_rdata", 32'(req1_rdata), 32'h0);
    req1_req = 1'b0;
    @(negedge OPB_CLK);
    rdsr = 0;
    for (int i = base; i < log_n; i++) if (log_mem[i] == 32'h50000000) rdsr++;
    check("po_rdsr", 32'(rdsr), 32'd4);
    check("po_ncmd", 32'(log_n - base), 32'd6);

    // Reset while in POLL_WAIT
    req0_wr = 1'b1; req0_addr = 16'h0060; req0_wdata = 8'h88; req0_req = 1'b1;
    n = 0;
    do begin
      @(negedge OPB_CLK);
      n++;
    end while (!(eep_we && eep_di == 32'h50000000) && n < 200);
    check("rst_mid_reach", 32'(n < 200), 32'h1);
    @(negedge OPB_CLK);
    OPB_RST = 1'b1;
    #1;
    check("rstm_busy", 32'(busy), 32'h0);
    check("rstm_we",   32'(eep_we), 32'h0);
    check("rstm_di",   eep_di, 32'h0);
    check("rstm_acks", 32'({req0_ack, req1_ack}), 32'h0);
    check("rstm_rsp",  32'({req0_rdata, req0_err, req1_rdata, req1_err}), 32'h0);
    req0_req = 1'b0;
    wip_stuck = 1'b0;
    repeat (2) @(negedge OPB_CLK);
    OPB_RST = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge OPB_CLK);
      if (req0_ack || req1_ack || busy) seen++;
    end
    check("rstm_quiet", 32'(seen), 32'd0);

    // Normal read after reset
    base = log_n;
    mem_byte = 8'h3C;
    req1_wr = 1'b0; req1_addr = 16'h0200; req1_req = 1'b1;
    wait_ack(200, who, n);
    check("post_who",   32'(who), 32'd1);
    check("post_rdata", 32'(req1_rdata), 32'h3C);
    check("post_err",   32'(req1_err), 32'h0);
    req1_req = 1'b0;
    @(negedge OPB_CLK);
    check("post_di", log_mem[base], 32'h30020000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
